// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: FSM states, key indices, debounce default.
package calc_pkg;

    typedef enum logic [1:0] {
        EDIT    = 2'd0,
        REQ     = 2'd1,
        ACKWAIT = 2'd2
    } state_t;

    localparam int KEY_OP   = 0;
    localparam int KEY_B    = 1;
    localparam int KEY_A    = 2;
    localparam int KEY_EXEC = 3;

    // 10 ms stability window at 50 MHz.
    localparam int DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/key_conditioner.sv
// One push-button path: 2-flop synchronizer, optional debounce (CALC_DEBOUNCE_EN), falling-edge press pulse.
module key_conditioner
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_settle;
    logic       w_lvl;

    if (DB_CYCLES < 1) begin : g_db_cycles_range
        $error("key_conditioner: DB_CYCLES must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_db  <= 1'b1;
        end else if (r_sync2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_lvl = r_db;
`else
    assign w_lvl = r_sync2;
`endif

    // Presses are only honoured once the synchronized key has been seen released
    // after reset, so a key held through reset cannot fire on release of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= 1'b0;
            r_armed  <= 1'b0;
            r_settle <= 2'b00;
        end else begin
            r_settle <= {r_settle[0], 1'b1};
            r_prev   <= w_lvl;
            if (r_settle[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign press = r_armed & r_prev & ~w_lvl;

endmodule

// File: rtl/calc_sequencer.sv
// Button-driven operand/op editor with a four-phase request/acknowledge handshake to an external ALU.
// Optional debounce on the keys is enabled with CALC_DEBOUNCE_EN.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  MAX_VAL   = 9,
    parameter int  N_OPS     = 4,
    parameter int  DB_CYCLES = DB_CYCLES_DEFAULT,
    localparam int OP_W      = (N_OPS > 1) ? $clog2(N_OPS) : 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [3:0]        KEY_N,
    input  logic              alu_ack,
    input  logic [DATA_W-1:0] alu_res1,
    input  logic [DATA_W-1:0] alu_res2,
    output logic [DATA_W-1:0] opnd_a,
    output logic [DATA_W-1:0] opnd_b,
    output logic [OP_W-1:0]   op_sel,
    output logic              alu_req,
    output logic [DATA_W-1:0] res1,
    output logic [DATA_W-1:0] res2,
    output logic              res_valid,
    output logic              busy
);

    logic [3:0]        w_press;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_res1;
    logic [DATA_W-1:0] r_res2;
    logic              r_rv;
    logic [DATA_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_b_nxt;
    logic [OP_W-1:0]   w_op_nxt;
    logic [DATA_W-1:0] w_res1_nxt;
    logic [DATA_W-1:0] w_res2_nxt;
    logic              w_rv_nxt;

    function automatic logic [DATA_W-1:0] opnd_inc(input logic [DATA_W-1:0] v);
        return (v == DATA_W'(MAX_VAL)) ? '0 : v + DATA_W'(1);
    endfunction

    function automatic logic [OP_W-1:0] op_inc(input logic [OP_W-1:0] v);
        return (v == OP_W'(N_OPS - 1)) ? '0 : v + OP_W'(1);
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_conditioner #(
            .DB_CYCLES(DB_CYCLES)
        ) u_key (
            .clk  (CLOCK_50),
            .rst_n(RESET_N),
            .key_n(KEY_N[i]),
            .press(w_press[i])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= EDIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Edits and an execute in the same cycle land together, so the request carries the new values.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_res1_nxt  = r_res1;
        w_res2_nxt  = r_res2;
        w_rv_nxt    = r_rv;
        case (r_state)
            EDIT: begin
                if (w_press[KEY_OP]) w_op_nxt = op_inc(r_op);
                if (w_press[KEY_A])  w_a_nxt  = opnd_inc(r_a);
                if (w_press[KEY_B])  w_b_nxt  = opnd_inc(r_b);
                if (w_press[KEY_OP] || w_press[KEY_A] || w_press[KEY_B]) w_rv_nxt = 1'b0;
                if (w_press[KEY_EXEC]) w_state_nxt = REQ;
            end
            REQ: begin
                if (alu_ack) begin
                    w_res1_nxt  = alu_res1;
                    w_res2_nxt  = alu_res2;
                    w_rv_nxt    = 1'b1;
                    w_state_nxt = ACKWAIT;
                end
            end
            ACKWAIT: begin
                if (!alu_ack) w_state_nxt = EDIT;
            end
            default: w_state_nxt = EDIT;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_res1 <= '0;
            r_res2 <= '0;
            r_rv   <= 1'b0;
        end else begin
            r_a    <= w_a_nxt;
            r_b    <= w_b_nxt;
            r_op   <= w_op_nxt;
            r_res1 <= w_res1_nxt;
            r_res2 <= w_res2_nxt;
            r_rv   <= w_rv_nxt;
        end
    end

    assign opnd_a    = r_a;
    assign opnd_b    = r_b;
    assign op_sel    = r_op;
    assign res1      = r_res1;
    assign res2      = r_res2;
    assign res_valid = r_rv;
    assign alu_req   = (r_state == REQ);
    assign busy      = (r_state != EDIT);

endmodule
